// File: rtl/snap64_capture_ctrl.sv
// Capture sequencer for the snap64 snapshot buffer: arms on a software edge,
// waits for an immediate or external trigger, then fills one BRAM depth of samples.
module snap64_capture_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_in,
  input  logic              ext_trig,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic [31:0]       status_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state;
  logic              arm_q;
  logic              done;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;

  logic arm_pulse;
  logic trig_sel;
  logic valid_gate;
  logic abort;
  logic wr_cond;
  logic last_wr;
  logic unused_ctrl;

  assign arm_pulse   = ctrl_in[0] & ~arm_q;
  assign trig_sel    = ctrl_in[1];
  assign valid_gate  = ctrl_in[2];
  assign abort       = ctrl_in[3];
  assign wr_cond     = ~valid_gate | din_valid;
  assign last_wr     = (wr_ptr == {ADDR_W{1'b1}});
  assign unused_ctrl = ^ctrl_in[31:4];

  // NOTE: every register here uses <= so all of them see the same pre-edge values.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state     <= S_IDLE;
      arm_q     <= 1'b0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      count     <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_data <= '0;
    end else begin
      arm_q   <= ctrl_in[0];
      bram_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          // Abort outranks a simultaneous arm edge: stay put.
          if (arm_pulse && !abort) begin
            state  <= S_ARMED;
            count  <= '0;
            wr_ptr <= '0;
            done   <= 1'b0;
          end
        end
        S_ARMED: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (!trig_sel || ext_trig) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (wr_cond) begin
            bram_we   <= 1'b1;
            bram_addr <= wr_ptr;
            bram_data <= din;
            wr_ptr    <= wr_ptr + 1'b1;
            count     <= count + 1'b1;
            if (last_wr) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status is decoded straight from the state registers, so it never lags the FSM.
  always_comb begin
    status_out             = '0;
    status_out[31]         = done;
    status_out[30]         = (state == S_ARMED);
    status_out[29]         = (state == S_CAPTURE);
    status_out[ADDR_W:0]   = count;
  end

endmodule
